multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control
Interface
REQ-001 Single clock Clk; Reset synchronous, active-high; all state changes on rising Clk.
REQ-002 Clk  input  1  system clock.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Opcode  input  6  IR[31:26], stable from the cycle after FETCH completes.
REQ-005 Funct  input  6  IR[5:0].
REQ-006 Zero  input  1  ALU zero flag, valid in the BRANCH cycle.
REQ-007 MemReady  input  1  memory access completes this cycle.
REQ-008 PCWrite  output  1  PC load enable.
REQ-009 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 MemRead  output  1  memory read request.
REQ-011 MemWrite  output  1  memory write request.
REQ-012 IRWrite  output  1  instruction register load.
REQ-013 RegDst  output  2  write register select: 00 = rt, 01 = rd, 10 = $31.
REQ-014 MemToReg  output  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-015 RegWrite  output  1  register file write enable.
REQ-016 ALUSrcA  output  1  ALU A: 0 = PC, 1 = rs.
REQ-017 ALUSrcB  output  2  ALU B: 00 = rt, 01 = const 4, 10 = ext imm, 11 = sign-ext imm<<2.
REQ-018 ALUOp  output  4  0000 add, 0001 sub, 0011 and, 0100 or, 0101 nor, 0110 xor, 1001 slt.
REQ-019 ExtOp  output  1  immediate extension: 1 = sign, 0 = zero.
REQ-020 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
REQ-021 IllegalOp  output  1  one-cycle pulse: unsupported instruction decoded.
REQ-022 State  output  4  current state encoding, for debug.
Function
REQ-023 States SHALL be FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, REXEC=6, RWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11, JAL=12, JR=13; codes 14–15 go to FETCH next cycle with no enables active.
REQ-024 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00. PCWrite and IRWrite assert only when MemReady=1, in which case next state = DECODE; otherwise hold FETCH.
REQ-025 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add. Latch Opcode/Funct internally. Dispatch: lw/sw -> MEMADDR; supported R-type -> REXEC; jr -> JR; addi/andi/ori/xori/slti -> IEXEC; beq/bne -> BRANCH; j -> JUMP; jal -> JAL.
REQ-026 Supported R-type Funct: add, sub, and, or, nor, xor, slt. Any other opcode or Funct SHALL pulse IllegalOp in DECODE and return to FETCH with no writes.
REQ-027 All-zero instruction (nop) SHALL return from DECODE to FETCH with no writes and no IllegalOp.
REQ-028 MEMADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, add; next state MEMREAD (lw) or MEMWRITE (sw).
REQ-029 MEMREAD/MEMWRITE: IorD=1 with MemRead or MemWrite held asserted until MemReady=1; then go to MEMWB (lw) or FETCH (sw).
REQ-030 MEMWB: RegWrite=1, RegDst=00, MemToReg=01.
REQ-031 REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp from Funct. RWB: RegWrite=1, RegDst=01, MemToReg=00.
REQ-032 IEXEC: ALUSrcA=1, ALUSrcB=10; addi=add/sign, andi=and/zero, ori=or/zero, xori=xor/zero, slti=slt/sign. IWB: RegWrite=1, RegDst=00, MemToReg=00.
REQ-033 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSource=01; PCWrite = beq ? Zero : !Zero.
REQ-034 JUMP: PCWrite=1, PCSource=10. JAL: same as JUMP, plus RegWrite=1, RegDst=10, MemToReg=10 (PC already holds PC+4). JR: PCWrite=1, PCSource=11.
REQ-035 Every write/retire state SHALL return to FETCH. Zero-wait latency: lw 5 cycles; R-type, I-type, and sw 4 cycles; branch, j, jal, and jr 3 cycles. Each MemReady=0 cycle adds one cycle.
REQ-036 Any output not set in a state SHALL be 0, so no write enable is active outside its listed state.
Reset
REQ-037 While Reset=1, every output SHALL be 0 and State SHALL load FETCH at the edge; this includes a mid-wait MEMWRITE, which is abandoned.
REQ-038 The first cycle after Reset deasserts SHALL be FETCH with MemRead=1.
Structure
REQ-039 State encodings, opcode/Funct constants, ALUOp codes, and mux-select encodings SHALL reside in shared package mc_pkg.
REQ-040 Funct/opcode-to-ALUOp/ExtOp mapping SHALL be a combinational sub-module mc_alu_decode; the FSM stays in multicycle_control.
Verification
REQ-041 add (Opcode 0, Funct 100000), MemReady=1 -> States 0,1,6,7; RegWrite=1 only in cycle 4 with RegDst=01; ALUOp=0000 in REXEC.
REQ-042 lw with MemReady low 2 cycles in MEMREAD -> States 0,1,2,3,3,3,4; MemRead held through all MEMREAD cycles; RegWrite with MemToReg=01 in the last cycle.
REQ-043 beq with Zero=1 -> PCWrite=1, PCSource=01 in BRANCH; bne with Zero=1 -> PCWrite=0; both return to FETCH.
REQ-044 jal -> 3 cycles; JAL cycle shows PCWrite=1, RegWrite=1, RegDst=10, MemToReg=10.
REQ-045 Opcode 111111 -> IllegalOp pulse for 1 cycle in DECODE, no writes; nop (all zero) -> no IllegalOp.
REQ-046 Reset asserted during MEMWRITE wait -> all outputs 0 that cycle; next State=0; MemWrite never reasserted.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode/funct, ALU and mux-select encodings for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMREAD = 4'd3, S_MEMWB = 4'd4,
    S_MEMWRITE = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7, S_IEXEC = 4'd8, S_IWB = 4'd9,
    S_BRANCH = 4'd10, S_JUMP = 4'd11, S_JAL = 4'd12, S_JR = 4'd13
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
                         OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_NOP = 6'h00, FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                         FN_SLT = 6'h2a;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0011,
                         ALU_OR = 4'b0100, ALU_NOR = 4'b0101, ALU_XOR = 4'b0110,
                         ALU_SLT = 4'b1001;
  localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BR = 2'b11;
  localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_RS = 2'b11;
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       ext_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/status inputs and control outputs between controller and datapath
interface multicycle_control_if;
  logic [5:0] Opcode, Funct;
  logic       Zero, MemReady;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtOp, IllegalOp;
  logic [1:0] RegDst, MemToReg, ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;
  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, IllegalOp, State
  );
  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, IllegalOp, State
  );
endinterface

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: maps R-type funct or I-type opcode to ALU operation and immediate extension
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       r_ok,
  output logic       i_ok
);
  logic [3:0] r_op, i_op;
  logic       i_ext;
  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_NOR:  r_op = ALU_NOR;
      FN_XOR:  r_op = ALU_XOR;
      FN_SLT:  r_op = ALU_SLT;
      default: r_ok = 1'b0;
    endcase
    i_op  = ALU_ADD;
    i_ext = 1'b1;
    i_ok  = 1'b1;
    case (opcode)
      OP_ADDI: i_op = ALU_ADD;
      OP_ANDI: begin i_op = ALU_AND; i_ext = 1'b0; end
      OP_ORI:  begin i_op = ALU_OR;  i_ext = 1'b0; end
      OP_XORI: begin i_op = ALU_XOR; i_ext = 1'b0; end
      OP_SLTI: i_op = ALU_SLT;
      default: i_ok = 1'b0;
    endcase
  end
  assign alu_op = (opcode == OP_RTYPE) ? r_op : i_op;
  assign ext_op = (opcode == OP_RTYPE) ? 1'b0 : i_ext;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-style control FSM driving datapath enables and mux selects
module multicycle_control
  import mc_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  multicycle_control_if.master bus
);
  state_e     state_q, state_d;
  logic [5:0] op_q, op_d, fn_q, fn_d, op, fn;
  logic [3:0] alu_op;
  logic       ext_op, r_ok, i_ok;
  ctrl_t      c, o;
  // DECODE sees the live instruction fields; later states use the copy latched there
  assign op = (state_q == S_DECODE) ? bus.Opcode : op_q;
  assign fn = (state_q == S_DECODE) ? bus.Funct : fn_q;
  mc_alu_decode u_dec (.opcode(op), .funct(fn), .alu_op(alu_op), .ext_op(ext_op), .r_ok(r_ok), .i_ok(i_ok));
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end
  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    fn_d    = fn_q;
    c       = '0;
    case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_write  = bus.MemReady;
        c.ir_write  = bus.MemReady;
        state_d     = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BR;
        op_d        = bus.Opcode;
        fn_d        = bus.Funct;
        case (bus.Opcode)
          OP_LW, OP_SW:   state_d = S_MEMADDR;
          OP_RTYPE:       state_d = (bus.Funct == FN_JR) ? S_JR : r_ok ? S_REXEC : S_FETCH;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default:        state_d = i_ok ? S_IEXEC : S_FETCH;
        endcase
        c.illegal = (state_d == S_FETCH) && (bus.Opcode != OP_RTYPE || bus.Funct != FN_NOP);
      end
      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.ext_op    = 1'b1;
        state_d     = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
        state_d    = bus.MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        state_d     = bus.MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MDR;
      end
      S_REXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = alu_op;
        state_d     = S_RWB;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = DST_RD;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = alu_op;
        c.ext_op    = ext_op;
        state_d     = S_IWB;
      end
      S_IWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_source = PCS_ALUOUT;
        c.pc_write  = (op_q == OP_BEQ) ? bus.Zero : !bus.Zero;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCS_JUMP;
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RA;
        c.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_RS;
      end
      default: ;
    endcase
  end
  assign o            = Reset ? '0 : c;
  assign bus.State    = Reset ? 4'd0 : state_q;
  assign bus.PCWrite  = o.pc_write;
  assign bus.IorD     = o.iord;
  assign bus.MemRead  = o.mem_read;
  assign bus.MemWrite = o.mem_write;
  assign bus.IRWrite  = o.ir_write;
  assign bus.RegDst   = o.reg_dst;
  assign bus.MemToReg = o.mem_to_reg;
  assign bus.RegWrite = o.reg_write;
  assign bus.ALUSrcA  = o.alu_src_a;
  assign bus.ALUSrcB  = o.alu_src_b;
  assign bus.ALUOp    = o.alu_op;
  assign bus.ExtOp    = o.ext_op;
  assign bus.PCSource = o.pc_source;
  assign bus.IllegalOp = o.illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences with a per-cycle expected-output scoreboard
module tb_multicycle_control;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  multicycle_control_if bus();
  multicycle_control dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  typedef struct { string tag; logic [24:0] v; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  logic [24:0] obs;
  assign obs = {bus.State, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.RegDst, bus.MemToReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.ExtOp, bus.PCSource, bus.IllegalOp};
  // field order: state pcw iord mrd mwr irw regdst memtoreg rw srca srcb aluop ext pcsrc ill
  function automatic logic [24:0] e(input logic [3:0] st, input logic pcw, iord, mrd, mwr, irw,
                                    input logic [1:0] rdst, m2r, input logic rw, sa,
                                    input logic [1:0] srcb, input logic [3:0] aop, input logic ext,
                                    input logic [1:0] pcs, input logic ill);
    return {st, pcw, iord, mrd, mwr, irw, rdst, m2r, rw, sa, srcb, aop, ext, pcs, ill};
  endfunction
  function automatic logic [24:0] fetch(input logic rdy);
    return e(4'd0, rdy, 0, 1, 0, rdy, 2'b00, 2'b00, 0, 0, 2'b01, 4'b0000, 0, 2'b00, 0);
  endfunction
  function automatic logic [24:0] decode(input logic ill);
    return e(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 4'b0000, 0, 2'b00, ill);
  endfunction
  function automatic logic [24:0] rexec(input logic [3:0] aop);
    return e(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, aop, 0, 2'b00, 0);
  endfunction
  function automatic logic [24:0] iexec(input logic [3:0] aop, input logic ext);
    return e(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, aop, ext, 2'b00, 0);
  endfunction
  function automatic logic [24:0] branch(input logic pcw);
    return e(4'd10, pcw, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 4'b0001, 0, 2'b01, 0);
  endfunction
  localparam logic [24:0] RWB      = e(4'd7, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 4'b0000, 0, 2'b00, 0);
  localparam logic [24:0] IWB      = e(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 4'b0000, 0, 2'b00, 0);
  localparam logic [24:0] MEMADDR  = e(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 4'b0000, 1, 2'b00, 0);
  localparam logic [24:0] MEMREAD  = e(4'd3, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 0);
  localparam logic [24:0] MEMWB    = e(4'd4, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 4'b0000, 0, 2'b00, 0);
  localparam logic [24:0] MEMWRITE = e(4'd5, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 0);
  localparam logic [24:0] JUMP     = e(4'd11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0, 2'b10, 0);
  localparam logic [24:0] JAL      = e(4'd12, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 4'b0000, 0, 2'b10, 0);
  localparam logic [24:0] JR       = e(4'd13, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0, 2'b11, 0);
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [24:0] v);
    exp_t x;
    bus.MemReady = mr;
    bus.Zero = z;
    sb.push_back('{tag, v});
    @(negedge Clk);
    x = sb.pop_front();
    checks++;
    assert (obs === x.v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", x.tag, obs, x.v);
    end
    @(posedge Clk);
    #1;
  endtask
  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    bus.Opcode = op;
    bus.Funct = fn;
    cyc("fetch", 1, 0, fetch(1));
  endtask
  initial begin
    bus.Opcode = '0;
    bus.Funct = '0;
    bus.MemReady = 1'b0;
    bus.Zero = 1'b0;
    cyc("reset0", 1, 0, '0);
    cyc("reset1", 1, 0, '0);
    Reset = 1'b0;
    instr(6'h00, 6'h20); cyc("add_dec", 1, 0, decode(0)); cyc("add_rexec", 1, 0, rexec(4'b0000)); cyc("add_rwb", 1, 0, RWB);
    instr(6'h00, 6'h27); cyc("nor_dec", 1, 0, decode(0)); cyc("nor_rexec", 1, 0, rexec(4'b0101)); cyc("nor_rwb", 1, 0, RWB);
    instr(6'h00, 6'h2a); cyc("slt_dec", 1, 0, decode(0)); cyc("slt_rexec", 1, 0, rexec(4'b1001)); cyc("slt_rwb", 1, 0, RWB);
    instr(6'h23, 6'h05); cyc("lw_dec", 1, 0, decode(0)); cyc("lw_addr", 1, 0, MEMADDR);
    cyc("lw_rd0", 0, 0, MEMREAD); cyc("lw_rd1", 0, 0, MEMREAD); cyc("lw_rd2", 1, 0, MEMREAD); cyc("lw_wb", 1, 0, MEMWB);
    bus.Opcode = 6'h2b;
    cyc("sw_fetch_wait", 0, 0, fetch(0)); cyc("sw_fetch", 1, 0, fetch(1)); cyc("sw_dec", 1, 0, decode(0));
    cyc("sw_addr", 1, 0, MEMADDR); cyc("sw_wr", 1, 0, MEMWRITE);
    instr(6'h08, 6'h3f); cyc("addi_dec", 1, 0, decode(0)); cyc("addi_exec", 1, 0, iexec(4'b0000, 1)); cyc("addi_wb", 1, 0, IWB);
    instr(6'h0c, 6'h00); cyc("andi_dec", 1, 0, decode(0)); cyc("andi_exec", 1, 0, iexec(4'b0011, 0)); cyc("andi_wb", 1, 0, IWB);
    instr(6'h0d, 6'h00); cyc("ori_dec", 1, 0, decode(0)); cyc("ori_exec", 1, 0, iexec(4'b0100, 0)); cyc("ori_wb", 1, 0, IWB);
    instr(6'h0e, 6'h00); cyc("xori_dec", 1, 0, decode(0)); cyc("xori_exec", 1, 0, iexec(4'b0110, 0)); cyc("xori_wb", 1, 0, IWB);
    instr(6'h0a, 6'h00); cyc("slti_dec", 1, 0, decode(0)); cyc("slti_exec", 1, 0, iexec(4'b1001, 1)); cyc("slti_wb", 1, 0, IWB);
    instr(6'h04, 6'h00); cyc("beq_dec", 1, 1, decode(0)); cyc("beq_z1", 1, 1, branch(1));
    instr(6'h04, 6'h00); cyc("beq0_dec", 1, 0, decode(0)); cyc("beq_z0", 1, 0, branch(0));
    instr(6'h05, 6'h00); cyc("bne_dec", 1, 1, decode(0)); cyc("bne_z1", 1, 1, branch(0));
    instr(6'h05, 6'h00); cyc("bne0_dec", 1, 0, decode(0)); cyc("bne_z0", 1, 0, branch(1));
    instr(6'h02, 6'h00); cyc("j_dec", 1, 0, decode(0)); cyc("j_jump", 1, 0, JUMP);
    instr(6'h03, 6'h00); cyc("jal_dec", 1, 0, decode(0)); cyc("jal_jal", 1, 0, JAL);
    instr(6'h00, 6'h08); cyc("jr_dec", 1, 0, decode(0)); cyc("jr_jr", 1, 0, JR);
    instr(6'h3f, 6'h20); cyc("ill_op_dec", 1, 0, decode(1));
    instr(6'h00, 6'h01); cyc("ill_fn_dec", 1, 0, decode(1));
    instr(6'h00, 6'h00); cyc("nop_dec", 1, 0, decode(0));
    instr(6'h2b, 6'h00); cyc("swr_dec", 1, 0, decode(0)); cyc("swr_addr", 1, 0, MEMADDR);
    cyc("swr_wait", 0, 0, MEMWRITE);
    Reset = 1'b1;
    cyc("swr_reset", 0, 0, '0);
    Reset = 1'b0;
    cyc("swr_after", 0, 0, fetch(0));
    bus.Opcode = 6'h00;
    cyc("post_fetch", 1, 0, fetch(1)); cyc("post_dec", 1, 0, decode(0));
    cyc("post_idle", 0, 0, fetch(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
